mac_accum_4bit: RTL and testbench
=================================

MAC_ACCUM_4BIT -- requirements
Module: mac_accum_4bit

Interface
REQ-001 The module SHALL have parameter ACC_W, default 16, setting the accumulator width in bits (legal range 9..32).
REQ-002 The module SHALL have parameter LEN, default 16, setting the maximum products per dot-product vector (legal range 2..256).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  pp and in_last are valid this cycle.
REQ-007 in_ready  output  1  block can accept a product this cycle.
REQ-008 pp  input  8  unsigned 4x4 integer partial product from the upstream multiplier stage.
REQ-009 in_last  input  1  the current beat is the final product of the vector.
REQ-010 clear  input  1  synchronous abort: discard the running sum and any held result.
REQ-011 out_valid  output  1  acc_out and sat hold a completed vector result.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 acc_out  output  ACC_W  unsigned accumulated sum.
REQ-014 sat  output  1  the sum saturated at least once during this vector.

Function
REQ-015 The FSM SHALL have two states: ACC (accepting products) and DONE (holding a result).
REQ-016 in_ready SHALL equal 1 in ACC and 0 in DONE; out_valid SHALL equal 1 in DONE and 0 in ACC.
REQ-017 A beat SHALL be accepted when in_valid and in_ready are both 1 and clear is 0.
REQ-018 On an accepted beat, acc SHALL become acc + zero-extended pp, visible on acc_out the next cycle (latency 1).
REQ-019 If acc + pp exceeds 2^ACC_W-1, acc SHALL become 2^ACC_W-1 and sat SHALL be set; sat SHALL stay set until the vector is released.
REQ-020 A beat counter SHALL count accepted beats from 0.
REQ-021 An accepted beat with in_last=1, or the accepted beat at count LEN-1, SHALL move the FSM to DONE on the next edge.
REQ-022 On the LEN-1 beat, in_last SHALL be ignored; the vector terminates either way.
REQ-023 In DONE, acc_out and sat SHALL stay stable until out_ready=1.
REQ-024 In DONE with out_ready=1, the next edge SHALL clear acc, sat and the counter to 0 and return the FSM to ACC.
REQ-025 A new beat SHALL be accepted no earlier than the cycle after result release, giving a one-cycle bubble.
REQ-026 clear=1 in any state SHALL set acc, sat and the counter to 0 and the FSM to ACC on the next edge.
REQ-027 clear SHALL take priority over a simultaneous beat or out_ready; the beat and the result are discarded.
REQ-028 in_valid=1 in DONE SHALL have no effect; upstream holds its beat.
REQ-029 pp=0 beats SHALL be accepted and counted normally.

Reset
REQ-030 While rst_n=0, the FSM SHALL be in ACC and acc, counter and sat SHALL be 0, so in_ready=1, out_valid=0, acc_out=0, sat=0.
REQ-031 Reset assertion mid-vector or in DONE SHALL discard all state immediately, without waiting for a clock edge.
REQ-032 After rst_n deasserts, the first beat SHALL be accepted on the first rising edge.

Structure
REQ-033 The state enum (ACC, DONE) and the default ACC_W and LEN constants SHALL live in the shared MAC package, for reuse by the multiplier-array top.
REQ-034 The saturating adder SHALL be one sub-module, sat_add, with inputs a[ACC_W], b[8] and outputs sum[ACC_W], ovf.
REQ-035 The counter width SHALL be $clog2(LEN).

Verification
REQ-036 Reset, then beats pp=3,5,7 with in_last on 7 -> out_valid=1 the cycle after the 7 beat, acc_out=15, sat=0.
REQ-037 With ACC_W=9, beats 200,200,200 with in_last on the third -> acc_out=511, sat=1.
REQ-038 LEN=4, eight back-to-back beats of 1 with in_last=0 and out_ready=1 -> two results of 4, with one-cycle in_ready=0 bubbles.
REQ-039 Result 10 in DONE, out_ready=0 for 5 cycles -> acc_out holds 10 and in_ready=0 throughout, then out_ready=1 releases it and the next vector starts from 0.
REQ-040 clear with a valid beat pp=9 mid-vector (running sum 20) -> next cycle acc_out=0, beat dropped, counter 0.
REQ-041 rst_n pulsed low asynchronously during DONE (acc_out=30) -> out_valid and acc_out go to 0 without a clock edge.

Source files
------------

// File: rtl/mac_accum_4bit_pkg.sv
// Shared MAC definitions: accumulator FSM states and default sizing,
// reused by the multiplier-array top.
package mac_accum_4bit_pkg;

  localparam int unsigned MAC_ACC_W = 16;
  localparam int unsigned MAC_LEN   = 16;
  localparam int unsigned PP_W      = 8;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } mac_state_e;

endpackage

// File: rtl/mac_accum_4bit_sat_add.sv
// Unsigned saturating adder: accumulator plus one 8-bit partial product,
// clamped to all-ones on carry out.
module sat_add
  import mac_accum_4bit_pkg::*;
#(
  parameter int unsigned ACC_W = MAC_ACC_W
) (
  input  logic [ACC_W-1:0] a,
  input  logic [PP_W-1:0]  b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  localparam int unsigned EXT_W = ACC_W + 1;

  logic [EXT_W-1:0] ext;

  always_comb begin
    ext = {1'b0, a} + EXT_W'(b);
    ovf = ext[ACC_W];
    sum = ovf ? '1 : ext[ACC_W-1:0];
  end

endmodule

// File: rtl/mac_accum_4bit.sv
// Dot-product accumulator: sums a vector of 4x4 partial products with
// saturation and holds the result until the consumer takes it.
module mac_accum_4bit
  import mac_accum_4bit_pkg::*;
#(
  parameter int unsigned ACC_W = MAC_ACC_W,
  parameter int unsigned LEN   = MAC_LEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PP_W-1:0]  pp,
  input  logic             in_last,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             sat
);

  localparam int unsigned CNT_W = $clog2(LEN);

  mac_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] sum_c;
  logic             ovf_c;
  logic             accept_c;
  logic             last_c;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .a   (acc_out),
    .b   (pp),
    .sum (sum_c),
    .ovf (ovf_c)
  );

  assign in_ready  = (state == ACC);
  assign out_valid = (state == DONE);

  // The LEN-1 beat closes the vector whatever in_last says.
  always_comb begin
    accept_c = in_valid & in_ready & ~clear;
    last_c   = in_last | (cnt == CNT_W'(LEN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACC;
      acc_out <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
    end else if (clear) begin
      state   <= ACC;
      acc_out <= '0;
      cnt     <= '0;
      sat     <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept_c) begin
            acc_out <= sum_c;
            sat     <= sat | ovf_c;
            cnt     <= cnt + CNT_W'(1);
            if (last_c) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state   <= ACC;
            acc_out <= '0;
            cnt     <= '0;
            sat     <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accum_4bit.sv
// Bench for mac_accum_4bit: three parameterisations (default, ACC_W=9,
// LEN=4) checked every cycle against an arithmetic vector model.
module tb_mac_accum_4bit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [3];
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [7:0] pp        [3];
  logic       in_last   [3];
  logic       clear     [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic       sat       [3];
  logic [15:0] acc0;
  logic [8:0]  acc1;
  logic [15:0] acc2;

  int checks = 0;
  int errors = 0;

  // Reference model: running vector sum, saturation flag, beat count, held flag.
  int m_acc  [3];
  bit m_sat  [3];
  int m_cnt  [3];
  bit m_done [3];
  int m_max  [3] = '{65535, 511, 65535};
  int m_len  [3] = '{16, 16, 4};

  mac_accum_4bit #(.ACC_W(16), .LEN(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .pp(pp[0]), .in_last(in_last[0]), .clear(clear[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .acc_out(acc0), .sat(sat[0]));

  mac_accum_4bit #(.ACC_W(9), .LEN(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .pp(pp[1]), .in_last(in_last[1]), .clear(clear[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .acc_out(acc1), .sat(sat[1]));

  mac_accum_4bit #(.ACC_W(16), .LEN(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .pp(pp[2]), .in_last(in_last[2]), .clear(clear[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .acc_out(acc2), .sat(sat[2]));

  function automatic logic [31:0] acc_of(int d);
    case (d)
      0:       return 32'(acc0);
      1:       return 32'(acc1);
      default: return 32'(acc2);
    endcase
  endfunction

  function automatic void model_clear(int d);
    m_acc[d]  = 0;
    m_sat[d]  = 1'b0;
    m_cnt[d]  = 0;
    m_done[d] = 1'b0;
  endfunction

  // One rising edge of the vector protocol, from the rules in plain arithmetic.
  function automatic void model_step(int d);
    int s;
    if (!rst_n[d] || clear[d]) begin
      model_clear(d);
    end else if (!m_done[d]) begin
      if (in_valid[d]) begin
        s = m_acc[d] + int'(pp[d]);
        if (s > m_max[d]) begin
          s = m_max[d];
          m_sat[d] = 1'b1;
        end
        m_acc[d] = s;
        m_cnt[d] = m_cnt[d] + 1;
        if (in_last[d] || m_cnt[d] == m_len[d]) m_done[d] = 1'b1;
      end
    end else if (out_ready[d]) begin
      model_clear(d);
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int d);
    chk($sformatf("d%0d in_ready", d),  32'(in_ready[d]),  32'(!m_done[d]));
    chk($sformatf("d%0d out_valid", d), 32'(out_valid[d]), 32'(m_done[d]));
    chk($sformatf("d%0d acc_out", d),   acc_of(d),         32'(m_acc[d]));
    chk($sformatf("d%0d sat", d),       32'(sat[d]),       32'(m_sat[d]));
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int d = 0; d < 3; d++) model_step(d);
    #1;
    for (int d = 0; d < 3; d++) check_dut(d);
  endtask

  task automatic beat(int d, logic [7:0] p, logic l);
    in_valid[d] = 1'b1;
    pp[d]       = p;
    in_last[d]  = l;
    cyc();
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
  endtask

  task automatic release_result(int d);
    out_ready[d] = 1'b1;
    cyc();
    out_ready[d] = 1'b0;
  endtask

  initial begin
    int results;
    int bubbles;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b1; in_valid[d] = 1'b0; pp[d] = '0; in_last[d] = 1'b0;
      clear[d] = 1'b0; out_ready[d] = 1'b0;
      model_clear(d);
    end
    #1;
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_dut(d);
    cyc();
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;

    // 3+5+7 with in_last on 7; first beat right after reset release.
    beat(0, 8'd3, 1'b0);
    beat(0, 8'd5, 1'b0);
    beat(0, 8'd7, 1'b1);
    chk("r36 out_valid", 32'(out_valid[0]), 32'd1);
    chk("r36 acc_out", acc_of(0), 32'd15);
    chk("r36 sat", 32'(sat[0]), 32'd0);
    release_result(0);

    // 9-bit accumulator saturates at 511.
    beat(1, 8'd200, 1'b0);
    beat(1, 8'd200, 1'b0);
    beat(1, 8'd200, 1'b1);
    chk("r37 acc_out", acc_of(1), 32'd511);
    chk("r37 sat", 32'(sat[1]), 32'd1);
    release_result(1);
    chk("r37 sat released", 32'(sat[1]), 32'd0);

    // LEN=4 streaming: eight beats of 1, consumer always ready.
    results = 0;
    bubbles = 0;
    in_valid[2] = 1'b1; pp[2] = 8'd1; in_last[2] = 1'b0; out_ready[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (out_valid[2] === 1'b1 && acc_of(2) === 32'd4) results++;
      if (in_ready[2] === 1'b0) bubbles++;
    end
    in_valid[2] = 1'b0; out_ready[2] = 1'b0;
    chk("r38 results", 32'(results), 32'd2);
    chk("r38 bubbles", 32'(bubbles), 32'd2);

    // Held result 10 with stalled consumer and a waiting upstream beat.
    beat(0, 8'd4, 1'b0);
    beat(0, 8'd6, 1'b1);
    in_valid[0] = 1'b1; pp[0] = 8'd5;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("r39 hold acc", acc_of(0), 32'd10);
      chk("r39 hold in_ready", 32'(in_ready[0]), 32'd0);
    end
    out_ready[0] = 1'b1;
    cyc();
    out_ready[0] = 1'b0;
    chk("r39 release acc", acc_of(0), 32'd0);
    cyc();
    in_valid[0] = 1'b0;
    chk("r39 restart acc", acc_of(0), 32'd5);
    beat(0, 8'd0, 1'b1);
    chk("r29 zero beat done", 32'(out_valid[0]), 32'd1);
    release_result(0);

    // clear beats a simultaneous beat; the next vector counts from 0.
    beat(2, 8'd10, 1'b0);
    beat(2, 8'd10, 1'b0);
    chk("r40 running", acc_of(2), 32'd20);
    in_valid[2] = 1'b1; pp[2] = 8'd9; clear[2] = 1'b1;
    cyc();
    in_valid[2] = 1'b0; clear[2] = 1'b0;
    chk("r40 cleared acc", acc_of(2), 32'd0);
    for (int i = 0; i < 3; i++) beat(2, 8'd1, 1'b0);
    chk("r40 not yet done", 32'(out_valid[2]), 32'd0);
    beat(2, 8'd1, 1'b0);
    chk("r40 done at LEN", 32'(out_valid[2]), 32'd1);
    chk("r40 done acc", acc_of(2), 32'd4);
    release_result(2);

    // Asynchronous reset while holding 30.
    beat(0, 8'd30, 1'b1);
    chk("r41 held", acc_of(0), 32'd30);
    #2;
    rst_n[0] = 1'b0;
    model_clear(0);
    #1;
    chk("r41 async out_valid", 32'(out_valid[0]), 32'd0);
    chk("r41 async acc", acc_of(0), 32'd0);
    chk("r41 async in_ready", 32'(in_ready[0]), 32'd1);
    @(negedge clk);
    rst_n[0] = 1'b1;

    // Randomised traffic on all three instances.
    for (int i = 0; i < 800; i++) begin
      for (int d = 0; d < 3; d++) begin
        in_valid[d]  = ($urandom_range(0, 3) != 0);
        pp[d]        = 8'($urandom_range(0, 255));
        in_last[d]   = ($urandom_range(0, 3) == 0);
        clear[d]     = ($urandom_range(0, 15) == 0);
        out_ready[d] = ($urandom_range(0, 1) == 1);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
